// File: rtl/pico_pkg.sv
// Shared definitions for the picoMIPS control unit: widths, opcodes,
// ALU function codes, operand-b select codes and the controller state type.
package pico_pkg;

   localparam int N   = 8;
   localparam int PCW = 6;
   localparam int OPW = 4;
   localparam int RAW = 3;
   localparam int IW  = 18;

   // ALU function codes shared with the ALU
   typedef enum logic [1:0] {
      RB    = 2'd0,
      RADD  = 2'd1,
      RSUB  = 2'd2,
      RMULT = 2'd3
   } alu_func_t;

   localparam logic [OPW-1:0] OP_NOP  = 4'd0;
   localparam logic [OPW-1:0] OP_ADD  = 4'd1;
   localparam logic [OPW-1:0] OP_ADDI = 4'd2;
   localparam logic [OPW-1:0] OP_SUB  = 4'd3;
   localparam logic [OPW-1:0] OP_SUBI = 4'd4;
   localparam logic [OPW-1:0] OP_MUL  = 4'd5;
   localparam logic [OPW-1:0] OP_MULI = 4'd6;
   localparam logic [OPW-1:0] OP_IN   = 4'd7;
   localparam logic [OPW-1:0] OP_BEQ  = 4'd8;
   localparam logic [OPW-1:0] OP_JMP  = 4'd9;
   localparam logic [OPW-1:0] OP_HALT = 4'd15;

   localparam logic [1:0] BSEL_RS  = 2'd0;
   localparam logic [1:0] BSEL_IMM = 2'd1;
   localparam logic [1:0] BSEL_IN  = 2'd2;

   typedef enum logic [2:0] {
      S_FETCH   = 3'd0,
      S_EXEC    = 3'd1,
      S_WAIT_HI = 3'd2,
      S_WAIT_LO = 3'd3,
      S_HALT    = 3'd4
   } state_t;

endpackage

// File: rtl/pico_decode.sv
// Combinational opcode decoder: ALU function, operand-b select, write
// enable and control-flow class for the instruction held in ir.
module pico_decode
   import pico_pkg::*;
(
   input  logic [OPW-1:0] i_opcode,
   output logic [1:0]     o_alu_func,
   output logic [1:0]     o_b_sel,
   output logic           o_we,
   output logic           o_is_branch,
   output logic           o_is_jump,
   output logic           o_is_in,
   output logic           o_is_halt
);

   // opcode to control-field table; NOP and undefined opcodes fall to default
   always_comb begin
      o_alu_func  = RB;
      o_b_sel     = BSEL_RS;
      o_we        = 1'b0;
      o_is_branch = 1'b0;
      o_is_jump   = 1'b0;
      o_is_in     = 1'b0;
      o_is_halt   = 1'b0;
      case (i_opcode)
         OP_ADD:  begin o_alu_func = RADD;  o_we = 1'b1; end
         OP_ADDI: begin o_alu_func = RADD;  o_b_sel = BSEL_IMM; o_we = 1'b1; end
         OP_SUB:  begin o_alu_func = RSUB;  o_we = 1'b1; end
         OP_SUBI: begin o_alu_func = RSUB;  o_b_sel = BSEL_IMM; o_we = 1'b1; end
         OP_MUL:  begin o_alu_func = RMULT; o_we = 1'b1; end
         OP_MULI: begin o_alu_func = RMULT; o_b_sel = BSEL_IMM; o_we = 1'b1; end
         OP_BEQ:  begin o_alu_func = RSUB;  o_is_branch = 1'b1; end
         OP_JMP:  o_is_jump = 1'b1;
         OP_IN:   o_is_in   = 1'b1;
         OP_HALT: o_is_halt = 1'b1;
         default: o_alu_func = RB;
      endcase
   end

endmodule

// File: rtl/pico_ctrl.sv
// picoMIPS multi-cycle controller: fetch/execute FSM, instruction register,
// program counter and the IN-port ready handshake.
module pico_ctrl
   import pico_pkg::*;
(
   input  logic            clk,
   input  logic            reset,
   output logic [PCW-1:0]  pc,
   input  logic [IW-1:0]   instr,
   input  logic            alu_zero,
   input  logic            in_ready,
   output logic [1:0]      alu_func,
   output logic [1:0]      b_sel,
   output logic [N-1:0]    imm,
   output logic [RAW-1:0]  rd_addr,
   output logic [RAW-1:0]  rs_addr,
   output logic            reg_we,
   output logic            halted
);

   localparam logic [PCW-1:0] PC_ONE = PCW'(1);

   state_t          r_state;
   logic [PCW-1:0]  r_pc;
   logic [IW-1:0]   r_ir;
   logic            r_halted;

   logic [1:0]      w_dec_func;
   logic [1:0]      w_dec_bsel;
   logic            w_dec_we;
   logic            w_is_branch;
   logic            w_is_jump;
   logic            w_is_in;
   logic            w_is_halt;

   pico_decode u_decode (
      .i_opcode    (r_ir[IW-1 -: OPW]),
      .o_alu_func  (w_dec_func),
      .o_b_sel     (w_dec_bsel),
      .o_we        (w_dec_we),
      .o_is_branch (w_is_branch),
      .o_is_jump   (w_is_jump),
      .o_is_in     (w_is_in),
      .o_is_halt   (w_is_halt)
   );

   // sequencer: state, pc, ir and halted flag
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= S_FETCH;
         r_pc     <= '0;
         r_ir     <= '0;
         r_halted <= 1'b0;
      end else begin
         case (r_state)
            S_FETCH: begin
               r_ir    <= instr;
               r_state <= S_EXEC;
            end
            S_EXEC: begin
               if (w_is_halt) begin
                  r_state  <= S_HALT;
                  r_halted <= 1'b1;
               end else if (w_is_in) begin
                  r_state <= S_WAIT_HI;
               end else begin
                  r_state <= S_FETCH;
                  // PCW-bit add of the low imm bits equals a sign-extended offset mod 2^PCW
                  if (w_is_jump)
                     r_pc <= r_ir[PCW-1:0];
                  else if (w_is_branch && alu_zero)
                     r_pc <= r_pc + r_ir[PCW-1:0];
                  else
                     r_pc <= r_pc + PC_ONE;
               end
            end
            S_WAIT_HI: begin
               if (in_ready)
                  r_state <= S_WAIT_LO;
            end
            S_WAIT_LO: begin
               if (!in_ready) begin
                  r_pc    <= r_pc + PC_ONE;
                  r_state <= S_FETCH;
               end
            end
            S_HALT:  r_halted <= 1'b1;
            default: r_state  <= S_FETCH;
         endcase
      end
   end

   // datapath strobes; reset masks the write strobe so no write lands on a reset edge
   always_comb begin
      alu_func = RB;
      b_sel    = BSEL_RS;
      reg_we   = 1'b0;
      case (r_state)
         S_EXEC: begin
            alu_func = w_dec_func;
            b_sel    = w_dec_bsel;
            reg_we   = w_dec_we & ~reset;
         end
         S_WAIT_HI: begin
            b_sel  = BSEL_IN;
            reg_we = in_ready & ~reset;
         end
         default: reg_we = 1'b0;
      endcase
   end

   assign pc      = r_pc;
   assign imm     = r_ir[N-1:0];
   assign rd_addr = r_ir[IW-OPW-1 -: RAW];
   assign rs_addr = r_ir[IW-OPW-RAW-1 -: RAW];
   assign halted  = r_halted;

endmodule

// File: tb/tb_pico_ctrl.sv
// Bench for pico_ctrl: instruction-level reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_pico_ctrl;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [5:0]  pc;
   logic [17:0] instr;
   logic        alu_zero = 1'b0;
   logic        in_ready = 1'b0;
   logic [1:0]  alu_func;
   logic [1:0]  b_sel;
   logic [7:0]  imm;
   logic [2:0]  rd_addr;
   logic [2:0]  rs_addr;
   logic        reg_we;
   logic        halted;

   logic [17:0] mem [64];
   int n_pass  = 0;
   int n_total = 0;

   assign instr = mem[pc];

   always #5 clk = ~clk;

   pico_ctrl dut (
      .clk      (clk),
      .reset    (reset),
      .pc       (pc),
      .instr    (instr),
      .alu_zero (alu_zero),
      .in_ready (in_ready),
      .alu_func (alu_func),
      .b_sel    (b_sel),
      .imm      (imm),
      .rd_addr  (rd_addr),
      .rs_addr  (rs_addr),
      .reg_we   (reg_we),
      .halted   (halted)
   );

   function automatic logic [17:0] enc(input int op, input int rd, input int rs, input int im);
      logic [3:0] f_op = 4'(op);
      logic [2:0] f_rd = 3'(rd);
      logic [2:0] f_rs = 3'(rs);
      logic [7:0] f_im = 8'(im);
      return {f_op, f_rd, f_rs, f_im};
   endfunction

   task automatic check(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
   endtask

   // ---------------- instruction-level reference model ----------------
   // phases: 0 fetch, 1 execute, 2 wait for ready high, 3 wait for ready low, 4 halted
   int          m_ph = 0;
   int          m_pc = 0;
   logic [17:0] m_ir = '0;
   bit          m_valid = 1'b0;

   always @(posedge clk) begin
      int op;
      int off;
      if (reset) begin
         m_ph = 0; m_pc = 0; m_valid = 1'b1;
      end else if (m_ph == 0) begin
         m_ir = mem[m_pc]; m_ph = 1;
      end else if (m_ph == 1) begin
         op = int'(m_ir[17:14]);
         if (op == 15) m_ph = 4;
         else if (op == 7) m_ph = 2;
         else begin
            m_ph = 0;
            if (op == 9) m_pc = int'(m_ir[7:0]) % 64;
            else if (op == 8 && alu_zero) begin
               off = int'(m_ir[5:0]);
               if (off >= 32) off = off - 64;
               m_pc = (m_pc + off + 64) % 64;
            end else m_pc = (m_pc + 1) % 64;
         end
      end else if (m_ph == 2) begin
         if (in_ready) m_ph = 3;
      end else if (m_ph == 3) begin
         if (!in_ready) begin m_pc = (m_pc + 1) % 64; m_ph = 0; end
      end
   end

   always @(negedge clk) begin
      int ef, eb, ew, op;
      if (m_valid) begin
         ef = 0; eb = 0; ew = 0;
         op = int'(m_ir[17:14]);
         if (m_ph == 1) begin
            if (op >= 1 && op <= 6) begin
               ef = (op + 1) / 2;
               eb = (op % 2 == 0) ? 1 : 0;
               ew = 1;
            end else if (op == 8) ef = 2;
         end else if (m_ph == 2) begin
            eb = 2;
            ew = in_ready ? 1 : 0;
         end
         if (reset) ew = 0;
         check("model pc", int'(pc), m_pc);
         check("model alu_func", int'(alu_func), ef);
         check("model b_sel", int'(b_sel), eb);
         check("model reg_we", int'(reg_we), ew);
         check("model halted", int'(halted), (m_ph == 4) ? 1 : 0);
         if (m_ph != 0) begin
            check("model imm", int'(imm), int'(m_ir[7:0]));
            check("model rd_addr", int'(rd_addr), int'(m_ir[13:11]));
            check("model rs_addr", int'(rs_addr), int'(m_ir[10:8]));
         end
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic cyc(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic clear_mem();
      for (int i = 0; i < 64; i++) mem[i] = '0;
   endtask

   task automatic do_reset();
      reset = 1'b1; in_ready = 1'b0; alu_zero = 1'b0;
      cyc(2);
      reset = 1'b0;
   endtask

   initial begin
      int pulses;
      int bad;
      clear_mem();

      // ADDI r1,5 then IN r2
      mem[0] = enc(2, 1, 0, 5);
      mem[1] = enc(7, 2, 0, 0);
      do_reset();
      check("reset pc", int'(pc), 0);
      check("reset halted", int'(halted), 0);
      check("reset reg_we", int'(reg_we), 0);
      check("reset alu_func", int'(alu_func), 0);
      check("reset b_sel", int'(b_sel), 0);
      cyc(1);
      check("addi alu_func", int'(alu_func), 1);
      check("addi b_sel", int'(b_sel), 1);
      check("addi imm", int'(imm), 5);
      check("addi rd", int'(rd_addr), 1);
      check("addi reg_we", int'(reg_we), 1);
      check("addi pc exec", int'(pc), 0);
      cyc(1);
      check("addi pc next", int'(pc), 1);
      cyc(2);
      pulses = 0; bad = 0;
      for (int i = 0; i < 15; i++) begin
         in_ready = (i >= 10 && i < 14) ? 1'b1 : 1'b0;
         #1;
         if (reg_we) begin
            pulses++;
            if (i != 10 || b_sel != 2'd2) bad++;
         end
         if (pc != 6'd1) bad++;
         @(posedge clk); #1;
      end
      check("in pulses", pulses, 1);
      check("in pulse timing", bad, 0);
      check("in pc after", int'(pc), 2);

      // BEQ at pc 3, offset -2, taken and not taken
      clear_mem();
      mem[0] = enc(9, 0, 0, 3);
      mem[3] = enc(8, 1, 2, 8'hFE);
      do_reset();
      alu_zero = 1'b1;
      cyc(2);
      check("jmp to 3", int'(pc), 3);
      cyc(1);
      check("beq reg_we", int'(reg_we), 0);
      check("beq alu_func", int'(alu_func), 2);
      cyc(1);
      check("beq taken pc", int'(pc), 1);
      do_reset();
      cyc(3);
      check("beq nt reg_we", int'(reg_we), 0);
      cyc(1);
      check("beq not taken pc", int'(pc), 4);

      // wrap-around: JMP at 63, then NOP at 63
      clear_mem();
      mem[0]  = enc(9, 0, 0, 63);
      mem[63] = enc(9, 0, 0, 0);
      do_reset();
      cyc(2);
      check("jmp to 63", int'(pc), 63);
      cyc(2);
      check("jmp wrap", int'(pc), 0);
      mem[63] = enc(0, 0, 0, 0);
      do_reset();
      cyc(2);
      check("jmp to 63 again", int'(pc), 63);
      cyc(2);
      check("nop wrap", int'(pc), 0);

      // HALT with idle stimulus, then reset
      clear_mem();
      mem[0] = enc(2, 1, 0, 5);
      mem[1] = enc(15, 0, 0, 0);
      do_reset();
      cyc(4);
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         in_ready = i[0];
         alu_zero = i[1];
         #1;
         if (halted != 1'b1 || pc != 6'd1 || reg_we != 1'b0) bad++;
         @(posedge clk); #1;
      end
      check("halt frozen", bad, 0);
      check("halted flag", int'(halted), 1);
      do_reset();
      check("halt reset pc", int'(pc), 0);
      check("halt reset halted", int'(halted), 0);

      // reset during wait-high with ready already high
      clear_mem();
      mem[0] = enc(7, 3, 0, 0);
      do_reset();
      in_ready = 1'b1;
      cyc(2);
      check("in early reg_we", int'(reg_we), 1);
      check("in early b_sel", int'(b_sel), 2);
      reset = 1'b1;
      #1;
      check("reset masks we", int'(reg_we), 0);
      @(posedge clk); #1;
      check("reset mid pc", int'(pc), 0);
      check("reset mid reg_we", int'(reg_we), 0);
      check("reset mid b_sel", int'(b_sel), 0);
      reset = 1'b0; in_ready = 1'b0;
      cyc(1);
      check("refetch exec", int'(b_sel), 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not end, %0d/%0d so far", n_pass, n_total);
      $fatal(1, "watchdog");
   end

endmodule
